// File: rtl/fifo_fwft_level.sv
// First-word-fall-through FIFO: synchronous-read RAM of C-1 words plus a head
// register. Provides a registered occupancy level, almost flags, flush and a sticky drop flag.
module fifo_fwft_level #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 5,
  parameter int AF_LEVEL    = (1 << DEPTH_WIDTH) - 2,
  parameter int AE_LEVEL    = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [DEPTH_WIDTH:0]   level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   drop_o
);

  localparam int                     CAP        = 1 << DEPTH_WIDTH;
  localparam int                     RAM_WORDS  = CAP - 1;
  localparam logic [DEPTH_WIDTH:0]   LEVEL_FULL = (DEPTH_WIDTH + 1)'(CAP);
  localparam logic [DEPTH_WIDTH:0]   LEVEL_ONE  = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_LAST   = DEPTH_WIDTH'(RAM_WORDS - 1);

  logic [DATA_WIDTH-1:0]  mem [RAM_WORDS];

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   level_q;
  logic [DEPTH_WIDTH:0]   level_nxt;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   wr_ready_q;
  logic                   af_q;
  logic                   ae_q;
  logic                   drop_q;

  logic                   wr_fire;
  logic                   rd_fire;
  logic                   ram_empty;
  logic                   load_bypass;
  logic                   ram_wr;
  logic                   ram_rd;
  logic                   af_nxt;
  logic                   ae_nxt;

  // RAM index wraps at C-1 words, which is not a power of two.
  function automatic logic [DEPTH_WIDTH-1:0] ptr_inc(input logic [DEPTH_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + DEPTH_WIDTH'(1);
  endfunction

  // The head register is always filled first, so the RAM holds level-1 words.
  always_comb begin
    wr_fire     = wr_valid_i && wr_ready_q;
    rd_fire     = out_valid_q && rd_ready_i;
    ram_empty   = (level_q <= LEVEL_ONE);
    load_bypass = wr_fire && (!out_valid_q || (rd_fire && ram_empty));
    ram_wr      = wr_fire && !load_bypass && !flush_i;
    ram_rd      = rd_fire && !ram_empty;
  end

  always_comb begin
    level_nxt = level_q;
    if (flush_i) begin
      level_nxt = '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   level_nxt = level_q + LEVEL_ONE;
        2'b01:   level_nxt = level_q - LEVEL_ONE;
        default: level_nxt = level_q;
      endcase
    end
    af_nxt = (int'(level_nxt) >= AF_LEVEL);
    ae_nxt = (int'(level_nxt) <= AE_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_ready_q  <= 1'b0;
      af_q        <= (AF_LEVEL <= 0);
      ae_q        <= (AE_LEVEL >= 0);
      drop_q      <= 1'b0;
    end else begin
      level_q    <= level_nxt;
      wr_ready_q <= (level_nxt < LEVEL_FULL);
      af_q       <= af_nxt;
      ae_q       <= ae_nxt;
      if (flush_i) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        out_valid_q <= 1'b0;
        drop_q      <= 1'b0;
      end else begin
        if (wr_valid_i && !wr_ready_q) begin
          drop_q <= 1'b1;
        end
        if (ram_wr) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        // The head register doubles as the RAM read register, so a read refills it at once.
        if (ram_rd) begin
          out_data_q <= mem[rd_ptr];
          rd_ptr     <= ptr_inc(rd_ptr);
        end else if (load_bypass) begin
          out_data_q <= wr_data_i;
        end
        if (ram_rd || load_bypass) begin
          out_valid_q <= 1'b1;
        end else if (rd_fire) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign wr_ready_o     = wr_ready_q;
  assign rd_data_o      = out_data_q;
  assign rd_valid_o     = out_valid_q;
  assign level_o        = level_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign drop_o         = drop_q;

endmodule

// File: tb/tb_fifo_fwft_level.sv
// Self-checking bench for fifo_fwft_level: directed scenarios plus random
// valid/ready traffic compared against a queue-based reference model.
module tb_fifo_fwft_level;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int CAP = 1 << AW;
  localparam int AF  = CAP - 2;
  localparam int AE  = 1;

  logic          clk;
  logic          nrst;
  logic          flush_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [AW:0]   level_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic          drop_o;

  int total_checks;
  int bad_checks;

  logic [DW-1:0] model_q [$];
  logic          model_ready;
  logic          model_drop;
  int            words_written;

  fifo_fwft_level #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .flush_i       (flush_i),
    .wr_data_i     (wr_data_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .level_o       (level_o),
    .almost_full_o (almost_full_o),
    .almost_empty_o(almost_empty_o),
    .drop_o        (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("rd_valid", 32'(rd_valid_o), 32'(model_q.size() > 0));
    if (model_q.size() > 0) checkOutput("rd_data", 32'(rd_data_o), 32'(model_q[0]));
    checkOutput("level", 32'(level_o), 32'(model_q.size()));
    checkOutput("wr_ready", 32'(wr_ready_o), 32'(model_ready));
    checkOutput("almost_full", 32'(almost_full_o), 32'(int'(model_q.size()) >= AF));
    checkOutput("almost_empty", 32'(almost_empty_o), 32'(int'(model_q.size()) <= AE));
    checkOutput("drop", 32'(drop_o), 32'(model_drop));
  endtask

  // One clock of traffic: predict the post-edge state from the queue model, then compare.
  task automatic applyStimulus(input logic fl, input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic do_wr;
    logic do_rd;
    flush_i    = fl;
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_ready_i = rr;
    do_wr = wv && model_ready;
    do_rd = rr && (model_q.size() > 0);
    if (fl) begin
      model_q.delete();
      model_drop = 1'b0;
    end else begin
      if (wv && !model_ready) model_drop = 1'b1;
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) begin
        model_q.push_back(wd);
        words_written++;
      end
    end
    model_ready = (model_q.size() < CAP);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    logic [DW-1:0] pattern;
    int            cycles;
    int            p_wr;
    int            p_rd;

    total_checks  = 0;
    bad_checks    = 0;
    words_written = 0;
    model_ready   = 1'b0;
    model_drop    = 1'b0;
    flush_i       = 1'b0;
    wr_valid_i    = 1'b0;
    wr_data_i     = '0;
    rd_ready_i    = 1'b0;
    nrst          = 1'b0;

    #12;
    checkOutput("reset_wr_ready", 32'(wr_ready_o), 32'd0);
    checkOutput("reset_rd_valid", 32'(rd_valid_o), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data_o), 32'd0);
    checkOutput("reset_level", 32'(level_o), 32'd0);
    checkOutput("reset_af", 32'(almost_full_o), 32'd0);
    checkOutput("reset_ae", 32'(almost_empty_o), 32'd1);
    checkOutput("reset_drop", 32'(drop_o), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset released");

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    checkOutput("single_data", 32'(rd_data_o), 32'h1234);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    $display("[TB] fill and drain");
    for (int i = 0; i < CAP; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
    checkOutput("full_level", 32'(level_o), 32'(CAP));
    applyStimulus(1'b0, 1'b1, 16'hdead, 1'b0);
    checkOutput("overflow_drop", 32'(drop_o), 32'd1);
    for (int i = 0; i < CAP; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("drained_valid", 32'(rd_valid_o), 32'd0);

    $display("[TB] streaming at level 1 and level %0d", CAP - 1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    pattern = 16'h0100;
    applyStimulus(1'b0, 1'b1, pattern, 1'b0);
    for (int i = 0; i < 100; i++) begin
      pattern = pattern + 16'd1;
      applyStimulus(1'b0, 1'b1, pattern, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < CAP - 1; i++) begin
      pattern = pattern + 16'd1;
      applyStimulus(1'b0, 1'b1, pattern, 1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      pattern = pattern + 16'd1;
      applyStimulus(1'b0, 1'b1, pattern, 1'b1);
    end
    checkOutput("stream31_level", 32'(level_o), 32'(CAP - 1));

    $display("[TB] flush with concurrent write");
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, DW'(16'h2000 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hbeef, 1'b1);
    checkOutput("flush_level", 32'(level_o), 32'd0);
    checkOutput("flush_wr_ready", 32'(wr_ready_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h5a5a, 1'b0);
    checkOutput("post_flush_head", 32'(rd_data_o), 32'h5a5a);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    $display("[TB] random traffic");
    words_written = 0;
    cycles = 0;
    p_wr = 70;
    p_rd = 70;
    while (words_written < 10000 && cycles < 40000) begin
      if (cycles % 400 == 0) begin
        p_wr = $urandom_range(20, 95);
        p_rd = $urandom_range(20, 95);
      end
      applyStimulus(1'b0, ($urandom_range(0, 99) < p_wr), DW'($urandom), ($urandom_range(0, 99) < p_rd));
      cycles++;
    end
    checkOutput("random_complete", 32'(words_written >= 10000), 32'd1);
    for (int i = 0; i < CAP + 2; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("random_drained", 32'(level_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
